// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state type and FIFO constants for the read-side drain engine
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } fifo_state_e;

  localparam int FIFO_DATA_W = 128;
  localparam int FIFO_CNT_W  = 4;
  localparam int FIFO_RD_LAT = 1;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry in-order register buffer; head entry drives the stream
module skid_buf2 #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic [1:0]   occ
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   cnt;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (cnt != 2'd0);
  assign push_ok = push && ((cnt != 2'd2) || pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b11: begin
          // occupancy unchanged: new word lands behind whatever stays resident
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head_data  = e0;
  assign head_valid = (cnt != 2'd0);
  assign occ        = cnt;

endmodule

// File: rtl/fifo_burst_unloader.sv
// rtl/fifo_burst_unloader.sv - drains bursts from the dual-clock FIFO read port onto a valid/ready stream
module fifo_burst_unloader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int CNT_W     = FIFO_CNT_W,
  parameter int BURST_LEN = 4,
  parameter int BCNT_W    = 16
) (
  input  logic              rd_clk,
  input  logic              rst,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  input  logic              fifo_valid,
  input  logic              fifo_underflow,
  input  logic [CNT_W-1:0]  fifo_rd_data_count,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err_underflow,
  output logic [BCNT_W-1:0] burst_done_cnt
);

  localparam int IF_W = $clog2(FIFO_RD_LAT + 2);

  fifo_state_e       state;
  fifo_state_e       state_nxt;
  logic [CNT_W-1:0]  blen;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  pushed;
  logic [IF_W-1:0]   inflight;
  logic              rst_q;
  logic              err_q;
  logic [BCNT_W-1:0] done_q;

  logic [DATA_W:0]   head;
  logic              head_valid;
  logic              head_last;
  logic [1:0]        occ;
  logic [2:0]        credit;
  logic              take;
  logic              stray;
  logic              accept;
  logic              tag_last;
  logic              start_full;
  logic              start_flush;

  // a returning word is only ours if a read is outstanding; anything else is stray
  assign take     = fifo_valid && (inflight != '0);
  assign stray    = fifo_valid && (inflight == '0) && !rst_q;
  assign accept   = head_valid && out_ready;
  assign tag_last = (pushed == blen - CNT_W'(1));

  assign start_full  = (fifo_rd_data_count >= CNT_W'(BURST_LEN));
  assign start_flush = flush && !fifo_empty && (fifo_rd_data_count != '0);

  // buffer slots already spoken for, crediting the word leaving this cycle
  assign credit = 3'(occ) + 3'(inflight) - 3'(accept);

  skid_buf2 #(.W(DATA_W + 1)) u_skid (
    .clk        (rd_clk),
    .rst        (rst),
    .push       (take),
    .push_data  ({tag_last, fifo_dout}),
    .pop        (accept),
    .head_data  (head),
    .head_valid (head_valid),
    .occ        (occ)
  );

  always_ff @(posedge rd_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (start_full || start_flush) state_nxt = BURST;
      end
      BURST: begin
        fifo_rd_en = !fifo_empty && (issued < blen) && (credit < 3'd2);
        if (fifo_rd_en && (issued == blen - CNT_W'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (accept && head_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      blen     <= '0;
      issued   <= '0;
      pushed   <= '0;
      inflight <= '0;
      rst_q    <= 1'b1;
      err_q    <= 1'b0;
      done_q   <= '0;
    end else begin
      rst_q    <= 1'b0;
      inflight <= inflight + IF_W'(fifo_rd_en) - IF_W'(take);
      if ((state == IDLE) && (state_nxt == BURST)) begin
        blen   <= start_full ? CNT_W'(BURST_LEN) : fifo_rd_data_count;
        issued <= '0;
        pushed <= '0;
      end else begin
        if (fifo_rd_en) issued <= issued + CNT_W'(1);
        if (take)       pushed <= pushed + CNT_W'(1);
      end
      if (fifo_underflow || stray) err_q <= 1'b1;
      if ((state == DRAIN) && accept && head_last) done_q <= done_q + BCNT_W'(1);
    end
  end

  assign head_last      = head[DATA_W];
  assign out_data       = head[DATA_W-1:0];
  assign out_valid      = head_valid;
  assign out_last       = head_valid && head_last;
  assign busy           = (state != IDLE);
  assign err_underflow  = err_q;
  assign burst_done_cnt = done_q;

endmodule
